// File: rtl/conv_frame_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : conv_frame_sequencer_if
// Brief  : Source stream, datapath control and result stream of the sequencer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface conv_frame_sequencer_if #(
    parameter int ROW_SIZE = 540,
    parameter int COL_SIZE = 540
);
    logic                        s_valid;
    logic                        s_ready;
    logic                        dp_en;
    logic                        dp_pad;
    logic                        dp_clr;
    logic                        m_valid;
    logic                        m_ready;
    logic [$clog2(COL_SIZE)-1:0] m_row;
    logic [$clog2(ROW_SIZE)-1:0] m_col;
    logic                        m_border;
    logic                        m_last;

    // master: the sequencer; slave: pixel source, datapath and result sink
    modport master (
        input  s_valid, m_ready,
        output s_ready, dp_en, dp_pad, dp_clr, m_valid, m_row, m_col, m_border, m_last
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, dp_en, dp_pad, dp_clr, m_valid, m_row, m_col, m_border, m_last
    );
endinterface

`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module : conv_frame_sequencer
// Brief  : Frame controller for the 3x3 Laplacian datapath: gates pixels in,
//          pads the tail to flush the pipe, tags each result with its position.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module conv_frame_sequencer #(
    parameter int ROW_SIZE = 540,
    parameter int COL_SIZE = 540,
    parameter int DP_LAT   = 3
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              abort,
    output logic                   busy,
    output logic                   done,
    conv_frame_sequencer_if.master bus
);

    localparam int c_N     = ROW_SIZE * COL_SIZE;
    localparam int c_LAT   = ROW_SIZE + 1 + DP_LAT;
    localparam int c_CNT_W = $clog2(c_N + c_LAT + 1);
    localparam int c_ROW_W = $clog2(COL_SIZE);
    localparam int c_COL_W = $clog2(ROW_SIZE);

    localparam logic [c_CNT_W-1:0] c_LAT_V    = c_CNT_W'(c_LAT);
    localparam logic [c_CNT_W-1:0] c_LAST_PIX = c_CNT_W'(c_N - 1);
    localparam logic [c_CNT_W-1:0] c_TOTAL    = c_CNT_W'(c_N + c_LAT);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(COL_SIZE - 1);
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(ROW_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_adv_cnt;
    logic [c_CNT_W-1:0]   r_in_cnt;
    logic                 r_m_valid;
    logic [c_ROW_W-1:0]   r_row;
    logic [c_COL_W-1:0]   r_col;

    logic w_stall;
    logic w_flush_act;
    logic w_adv;
    logic w_accept;
    logic w_last;
    logic w_res_hs;

    assign w_stall     = r_m_valid & ~bus.m_ready;
    // FLUSH stays entered until the last result drains, but pads only LAT times
    assign w_flush_act = (r_state == ST_FLUSH) && (r_adv_cnt < c_TOTAL);
    assign w_adv       = ~w_stall & (((r_state == ST_RUN) & bus.s_valid) | w_flush_act);
    assign w_accept    = w_adv & (r_state == ST_RUN);
    assign w_last      = r_m_valid && (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
    assign w_res_hs    = r_m_valid & bus.m_ready & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = (r_state != ST_IDLE);
        done       = (r_state == ST_DONE);
        bus.dp_clr = (r_state == ST_CLEAR);
        bus.s_ready = (r_state == ST_RUN) & ~w_stall;
        bus.dp_en  = w_adv;
        bus.dp_pad = w_flush_act;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_RUN;
            ST_RUN:   if (w_accept && (r_in_cnt == c_LAST_PIX)) w_next = ST_FLUSH;
            ST_FLUSH: if (w_res_hs) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_adv_cnt <= '0;
            r_in_cnt  <= '0;
            r_m_valid <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
        end else if (abort || (r_state == ST_CLEAR) || (r_state == ST_DONE)) begin
            r_adv_cnt <= '0;
            r_in_cnt  <= '0;
            r_m_valid <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
        end else begin
            if (w_adv) begin
                r_adv_cnt <= r_adv_cnt + 1'b1;
                r_m_valid <= (r_adv_cnt >= c_LAT_V);
                // first result sits at (0,0); each later one steps raster position
                if (r_adv_cnt > c_LAT_V) begin
                    if (r_col == c_COL_LAST) begin
                        r_col <= '0;
                        r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + 1'b1;
            end
        end
    end

    assign bus.m_valid  = r_m_valid;
    assign bus.m_row    = r_row;
    assign bus.m_col    = r_col;
    assign bus.m_last   = w_last;
    assign bus.m_border = r_m_valid && ((r_row == '0) || (r_row == c_ROW_LAST) ||
                                        (r_col == '0) || (r_col == c_COL_LAST));

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_conv_frame_sequencer
// Brief  : Directed bench for conv_frame_sequencer on a 4x4 frame (N=16, LAT=8).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_conv_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    int   errors = 0;
    int   checks = 0;

    conv_frame_sequencer_if #(.ROW_SIZE(4), .COL_SIZE(4)) bus ();

    conv_frame_sequencer #(.ROW_SIZE(4), .COL_SIZE(4), .DP_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_sready"}, bus.s_ready, 0);
        chk({tag, "_en"},     bus.dp_en, 0);
        chk({tag, "_pad"},    bus.dp_pad, 0);
        chk({tag, "_clr"},    bus.dp_clr, 0);
        chk({tag, "_mvalid"}, bus.m_valid, 0);
        chk({tag, "_row"},    bus.m_row, 0);
        chk({tag, "_col"},    bus.m_col, 0);
        chk({tag, "_border"}, bus.m_border, 0);
        chk({tag, "_last"},   bus.m_last, 0);
    endtask

    // mode 0: free-running (plus a start pulse while busy), 1: sink stall, 2: gappy source
    task automatic run_frame(input int mode, input int exp_done);
        int idx     = 0;
        int done_at = -1;
        int r;
        int cl;
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            @(posedge clk); #1;
            start       = (c == 0) || (mode == 0 && c == 5);
            bus.s_valid = (mode == 2) ? ((c % 2) == 0) : 1'b1;
            bus.m_ready = !(mode == 1 && c >= 12 && c <= 14);
            #1;
            if (bus.m_valid && bus.m_ready) begin
                r  = idx / 4;
                cl = idx % 4;
                chk("res_row", bus.m_row, r);
                chk("res_col", bus.m_col, cl);
                chk("res_border", bus.m_border, (r == 0 || r == 3 || cl == 0 || cl == 3));
                chk("res_last", bus.m_last, (idx == 15));
                idx++;
            end
            if (mode == 0) begin
                chk("clr",    bus.dp_clr,  c == 1);
                chk("sready", bus.s_ready, c >= 2 && c <= 17);
                chk("en",     bus.dp_en,   c >= 2 && c <= 25);
                chk("pad",    bus.dp_pad,  c >= 18 && c <= 25);
                chk("mvalid", bus.m_valid, c >= 11 && c <= 26);
                chk("busy",   busy,        c >= 1 && c <= 27);
                chk("done",   done,        c == 27);
            end
            if (mode == 1 && c >= 12 && c <= 14) begin
                chk("stall_mvalid", bus.m_valid, 1);
                chk("stall_row",    bus.m_row, 0);
                chk("stall_col",    bus.m_col, 1);
                chk("stall_sready", bus.s_ready, 0);
                chk("stall_en",     bus.dp_en, 0);
            end
            if (mode == 1 && c == 16) begin
                chk("post_stall_valid", bus.m_valid, 1);
                chk("post_stall_col",   bus.m_col, 2);
            end
            if (mode == 2 && c >= 2 && c <= 32)
                chk("gap_en", bus.dp_en, (c % 2) == 0);
            if (done) done_at = c;
        end
        start = 1'b0;
        chk("result_count", idx, 16);
        chk("done_cycle", done_at, exp_done);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        run_frame(0, 27);
        run_frame(1, 30);
        run_frame(2, 42);

        // abort mid-RUN after six accepted pixels
        @(posedge clk); #1;
        start = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 8) begin
                bus.s_valid = 1'b0;
                abort = 1'b1;
            end
        end
        #1 chk("abort_busy_before", busy, 1);
        @(posedge clk); #1;
        abort = 1'b0; bus.s_valid = 1'b1;
        #1;
        chk("abort_busy",   busy, 0);
        chk("abort_mvalid", bus.m_valid, 0);
        chk("abort_sready", bus.s_ready, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end

        // abort wins over a simultaneous start
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        #1 chk("abort_beats_start", busy, 0);

        run_frame(0, 27);

        // asynchronous reset while flushing
        @(posedge clk); #1;
        start = 1'b1; bus.s_valid = 1'b1; bus.m_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #1;
        chk("flush_pad",    bus.dp_pad, 1);
        chk("flush_mvalid", bus.m_valid, 1);
        chk("flush_row",    bus.m_row, 2);
        chk("flush_col",    bus.m_col, 1);
        #1 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
